// File: rtl/stream_demux_1to4_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
// Lane count, select width and lane index constants live here so top and bench agree.
package stream_demux_1to4_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    localparam logic [SEL_W-1:0] LANE0 = 2'd0;
    localparam logic [SEL_W-1:0] LANE1 = 2'd1;
    localparam logic [SEL_W-1:0] LANE2 = 2'd2;
    localparam logic [SEL_W-1:0] LANE3 = 2'd3;

    // Binary lane select to one-hot lane enable, gated by a qualifier.
    function automatic logic [NUM_LANES-1:0] sel_to_onehot(
        input logic [SEL_W-1:0] sel,
        input logic             en
    );
        logic [NUM_LANES-1:0] oh;
        oh = '0;
        unique case (sel)
            LANE0:   oh[0] = en;
            LANE1:   oh[1] = en;
            LANE2:   oh[2] = en;
            LANE3:   oh[3] = en;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/stream_demux_1to4_lane.sv
// One-entry holding buffer for a single demux lane.
// Refill in the same cycle as a drain keeps the lane full, giving one word per cycle.
module demux_lane
    import stream_demux_1to4_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_drain,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data,
    output logic              o_can_load
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              w_full_d;
    logic [DATA_W-1:0] w_data_d;
    logic              w_take;

    always_comb begin
        w_take   = r_full & i_drain;
        w_full_d = r_full;
        w_data_d = r_data;
        if (i_load) begin
            w_full_d = 1'b1;
            w_data_d = i_load_data;
        end else if (w_take) begin
            // Data is left in place after a drain; only the flag matters downstream.
            w_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            r_full <= w_full_d;
            r_data <= w_data_d;
        end
    end

    assign o_full     = r_full;
    assign o_data     = r_data;
    assign o_can_load = ~r_full | i_drain;

endmodule

// File: rtl/stream_demux_1to4.sv
// 1-to-4 valid/ready demultiplexer: each accepted word lands in its selected lane's
// one-entry buffer and is held there until that lane's consumer takes it.
module stream_demux_1to4
    import stream_demux_1to4_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data0,
    output logic [DATA_W-1:0]    out_data1,
    output logic [DATA_W-1:0]    out_data2,
    output logic [DATA_W-1:0]    out_data3,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [CNT_W-1:0]     acc_count
);

    logic [NUM_LANES-1:0] w_can_load;
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_load;
    logic [DATA_W-1:0]    w_lane_data [NUM_LANES];
    logic                 w_ready;
    logic                 w_accept;
    logic [CNT_W-1:0]     r_acc_cnt;

    // Readiness follows the addressed lane only, independent of in_valid.
    assign w_ready  = w_can_load[in_sel];
    assign w_accept = in_valid & w_ready;
    assign w_load   = sel_to_onehot(in_sel, w_accept);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_load      (w_load[g]),
            .i_load_data (in_data),
            .i_drain     (out_ready[g]),
            .o_full      (w_full[g]),
            .o_data      (w_lane_data[g]),
            .o_can_load  (w_can_load[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = w_full;
    assign out_data0 = w_lane_data[LANE0];
    assign out_data1 = w_lane_data[LANE1];
    assign out_data2 = w_lane_data[LANE2];
    assign out_data3 = w_lane_data[LANE3];
    assign acc_count = r_acc_cnt;

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: reset, fill, backpressure, pass-through,
// counter wrap and mid-cycle reset, checked with immediate assertions.
module tb_stream_demux_1to4;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] acc_count;

    int total;
    int bad;

    stream_demux_1to4 #(
        .DATA_W (32),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_count (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 32'hDEAD_BEEF);

        // 1. reset held with a valid word present
        repeat (3) tick();
        chk("rst_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_cnt", {16'd0, acc_count}, 32'h0);
        chk("rst_data0", out_data0, 32'h0);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        chk("post_rst_valid", {28'd0, out_valid}, 32'h0);

        // 2. fill all four lanes, then hit a full lane
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'hA0 + 32'(i));
            #1;
            chk("fill_ready", {31'd0, in_ready}, 32'h1);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_valid", {28'd0, out_valid}, 32'hF);
        chk("fill_d0", out_data0, 32'hA0);
        chk("fill_d1", out_data1, 32'hA1);
        chk("fill_d2", out_data2, 32'hA2);
        chk("fill_d3", out_data3, 32'hA3);
        chk("fill_cnt", {16'd0, acc_count}, 32'd4);
        drive(1'b1, 2'd2, 32'hB0);
        #1;
        chk("full_ready", {31'd0, in_ready}, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("full_hold_d2", out_data2, 32'hA2);
        chk("full_hold_cnt", {16'd0, acc_count}, 32'd4);

        // 3. drain and refill lane 1 in the same cycle
        out_ready = 4'b0010;
        drive(1'b1, 2'd1, 32'h55);
        #1;
        chk("refill_ready", {31'd0, in_ready}, 32'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("refill_d1", out_data1, 32'h55);
        chk("refill_valid", {28'd0, out_valid}, 32'hF);
        chk("refill_cnt", {16'd0, acc_count}, 32'd5);

        // 4. stream ten words through lane 0 while lane 3 is back-pressured
        out_ready = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 2'd0, 32'hC0 + 32'(k));
            #1;
            chk("stream_ready", {31'd0, in_ready}, 32'h1);
            tick();
            chk("stream_d0", out_data0, 32'hC0 + 32'(k));
        end
        in_valid = 1'b0;
        chk("stream_d3", out_data3, 32'hA3);
        chk("stream_valid", {28'd0, out_valid}, 32'hF);
        chk("stream_cnt", {16'd0, acc_count}, 32'd15);
        tick();
        chk("drain_only", {28'd0, out_valid}, 32'hE);

        // drain of lane 3 alongside accept into empty lane 0
        out_ready = 4'b1000;
        drive(1'b1, 2'd0, 32'h77);
        tick();
        chk("mixed_valid", {28'd0, out_valid}, 32'h7);
        chk("mixed_d0", out_data0, 32'h77);
        chk("mixed_cnt", {16'd0, acc_count}, 32'd16);

        // invalid input with a select: no state change; ready on empty lane harmless
        out_ready = 4'b1000;
        drive(1'b0, 2'd3, 32'h1234);
        tick();
        out_ready = 4'b0000;
        chk("idle_valid", {28'd0, out_valid}, 32'h7);
        chk("idle_d3", out_data3, 32'hA3);
        chk("idle_cnt", {16'd0, acc_count}, 32'd16);

        // 5. counter wrap
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 32'hF0);
        repeat (65519) tick();
        chk("cnt_max", {16'd0, acc_count}, 32'hFFFF);
        tick();
        chk("cnt_wrap", {16'd0, acc_count}, 32'h0);
        in_valid = 1'b0;
        tick();
        chk("wrap_drained", {28'd0, out_valid}, 32'h0);
        out_ready = 4'b0000;

        // 6. mid-cycle reset pulse with all lanes full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'h10 + 32'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {28'd0, out_valid}, 32'hF);
        chk("pre_rst_cnt", {16'd0, acc_count}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {28'd0, out_valid}, 32'h0);
        chk("mid_rst_d1", out_data1, 32'h0);
        chk("mid_rst_d3", out_data3, 32'h0);
        chk("mid_rst_cnt", {16'd0, acc_count}, 32'h0);
        rst = 1'b0;
        tick();
        chk("after_rst_valid", {28'd0, out_valid}, 32'h0);
        drive(1'b1, 2'd2, 32'h99);
        tick();
        in_valid = 1'b0;
        chk("resume_valid", {28'd0, out_valid}, 32'h4);
        chk("resume_d2", out_data2, 32'h99);
        chk("resume_cnt", {16'd0, acc_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
